// File: rtl/risc_hazard_ctrl.sv
// Pipeline hazard controller: sequences load-use stalls, taken-branch flushes and
// multi-cycle EX waits, gates forward selects and keeps saturating event counters.
module risc_hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ha,
  input  logic             hb,
  input  logic             ex_rw,
  input  logic [4:0]       ex_da,
  input  logic             ex_load,
  input  logic [4:0]       dof_aa,
  input  logic [4:0]       dof_ba,
  input  logic             dof_ma,
  input  logic             dof_mb,
  input  logic             branch_taken,
  input  logic             mc_start,
  input  logic             mc_done,
  output logic             stall_pc,
  output logic             stall_ir,
  output logic             hold_ex,
  output logic             bubble_ex,
  output logic             flush,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             mc_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TMO_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic stall_inc, flush_inc;
  logic stall_pc_c, stall_ir_c, hold_ex_c, bubble_ex_c, flush_c, mc_error_c;

  assign load_use = ex_load & ex_rw & (|ex_da) &
                    ((~dof_ma & (dof_aa == ex_da)) | (~dof_mb & (dof_ba == ex_da)));

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    stall_pc_c  = 1'b0;
    stall_ir_c  = 1'b0;
    hold_ex_c   = 1'b0;
    bubble_ex_c = 1'b0;
    flush_c     = 1'b0;
    mc_error_c  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          flush_c   = 1'b1;
          flush_inc = 1'b1;
          state_d   = ST_FLUSH;
        end else if (mc_start) begin
          stall_pc_c = 1'b1;
          stall_ir_c = 1'b1;
          hold_ex_c  = 1'b1;
          tmo_d      = '0;
          state_d    = ST_MC_WAIT;
        end else if (load_use) begin
          stall_pc_c  = 1'b1;
          stall_ir_c  = 1'b1;
          bubble_ex_c = 1'b1;
          stall_inc   = 1'b1;
        end
      end
      ST_MC_WAIT: begin
        if (mc_done) begin
          state_d = ST_RUN;
        end else begin
          stall_pc_c = 1'b1;
          stall_ir_c = 1'b1;
          stall_inc  = 1'b1;
          // On timeout the stuck op is dropped: EX gets a bubble instead of being held.
          if (tmo_q == TMO_LAST) begin
            mc_error_c  = 1'b1;
            bubble_ex_c = 1'b1;
            state_d     = ST_RUN;
          end else begin
            hold_ex_c = 1'b1;
            tmo_d     = tmo_q + 1'b1;
          end
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_comb begin
    stall_pc  = stall_pc_c;
    stall_ir  = stall_ir_c;
    hold_ex   = hold_ex_c;
    bubble_ex = bubble_ex_c;
    flush     = flush_c;
    mc_error  = mc_error_c;
    fwd_a     = ha & ~load_use & (state_q != ST_FLUSH) & ~stall_pc_c & ~stall_ir_c;
    fwd_b     = hb & ~load_use & (state_q != ST_FLUSH) & ~stall_pc_c & ~stall_ir_c;
    // Reset forces outputs low without waiting for the state flop to settle.
    if (!reset_n) begin
      stall_pc  = 1'b0;
      stall_ir  = 1'b0;
      hold_ex   = 1'b0;
      bubble_ex = 1'b0;
      flush     = 1'b0;
      mc_error  = 1'b0;
      fwd_a     = 1'b0;
      fwd_b     = 1'b0;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      tmo_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_risc_hazard_ctrl.sv
// Randomized plus directed bench for risc_hazard_ctrl against a cycle-level reference model.
module tb_risc_hazard_ctrl;

  localparam int CNT_W      = 4;
  localparam int MC_TIMEOUT = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             ha, hb, ex_rw, ex_load, dof_ma, dof_mb;
  logic             branch_taken, mc_start, mc_done;
  logic [4:0]       ex_da, dof_aa, dof_ba;
  logic             stall_pc, stall_ir, hold_ex, bubble_ex, flush, fwd_a, fwd_b, mc_error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: plain counters and flags.
  bit m_waiting, m_after_branch;
  int m_waited, m_stalls, m_flushes;

  risc_hazard_ctrl #(.CNT_W(CNT_W), .MC_TIMEOUT(MC_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .ha(ha), .hb(hb), .ex_rw(ex_rw), .ex_da(ex_da),
    .ex_load(ex_load), .dof_aa(dof_aa), .dof_ba(dof_ba), .dof_ma(dof_ma), .dof_mb(dof_mb),
    .branch_taken(branch_taken), .mc_start(mc_start), .mc_done(mc_done),
    .stall_pc(stall_pc), .stall_ir(stall_ir), .hold_ex(hold_ex), .bubble_ex(bubble_ex),
    .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_error(mc_error),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    {ha, hb, ex_rw, ex_load, dof_ma, dof_mb, branch_taken, mc_start, mc_done} = '0;
    ex_da = '0; dof_aa = '0; dof_ba = '0;
  endtask

  task automatic model_reset();
    m_waiting = 0; m_after_branch = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
  endtask

  // Compare one cycle against the model, then advance to the next cycle.
  task automatic step();
    bit lu, e_spc, e_sir, e_hold, e_bub, e_fl, e_err, e_fa, e_fb;
    bit n_waiting, n_after;
    int n_waited, n_st, n_fl;
    #1;
    lu = ex_load && ex_rw && (ex_da != 0) &&
         ((!dof_ma && dof_aa == ex_da) || (!dof_mb && dof_ba == ex_da));
    {e_spc, e_sir, e_hold, e_bub, e_fl, e_err} = '0;
    n_waiting = m_waiting; n_after = 0; n_waited = m_waited;
    n_st = m_stalls; n_fl = m_flushes;
    if (m_after_branch) begin
      // killed instruction in DOF: nothing happens
    end else if (m_waiting) begin
      if (mc_done) n_waiting = 0;
      else begin
        e_spc = 1; e_sir = 1; n_st++;
        if (m_waited == MC_TIMEOUT - 1) begin
          e_err = 1; e_bub = 1; n_waiting = 0;
        end else begin
          e_hold = 1; n_waited++;
        end
      end
    end else if (branch_taken) begin
      e_fl = 1; n_fl++; n_after = 1;
    end else if (mc_start) begin
      e_spc = 1; e_sir = 1; e_hold = 1; n_waiting = 1; n_waited = 0;
    end else if (lu) begin
      e_spc = 1; e_sir = 1; e_bub = 1; n_st++;
    end
    e_fa = ha && !lu && !m_after_branch && !e_spc;
    e_fb = hb && !lu && !m_after_branch && !e_spc;
    check("stall_pc", stall_pc, e_spc);
    check("stall_ir", stall_ir, e_sir);
    check("hold_ex", hold_ex, e_hold);
    check("bubble_ex", bubble_ex, e_bub);
    check("flush", flush, e_fl);
    check("mc_error", mc_error, e_err);
    check("fwd_a", fwd_a, e_fa);
    check("fwd_b", fwd_b, e_fb);
    check("stall_cnt", stall_cnt, m_stalls);
    check("flush_cnt", flush_cnt, m_flushes);
    @(posedge clk);
    m_waiting = n_waiting; m_after_branch = n_after; m_waited = n_waited;
    m_stalls = (n_st > CNT_MAX) ? CNT_MAX : n_st;
    m_flushes = (n_fl > CNT_MAX) ? CNT_MAX : n_fl;
    @(negedge clk);
  endtask

  task automatic set_load_use();
    clr(); ex_load = 1; ex_rw = 1; ex_da = 5'd5; dof_aa = 5'd5; ha = 1;
  endtask

  initial begin
    clr();
    reset_n = 0;
    model_reset();
    mc_start = 1; ha = 1;
    #12;
    check("rst_stall_pc", stall_pc, 0);
    check("rst_fwd_a", fwd_a, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    @(negedge clk);
    reset_n = 1;
    clr();
    step();

    // load-use via port A, then release
    set_load_use(); step();
    clr(); step();
    // no stall when r0 is the target or A is a constant; plain forward
    set_load_use(); ex_da = 0; dof_aa = 0; step();
    set_load_use(); dof_ma = 1; step();
    clr(); ex_rw = 1; ex_da = 5'd7; dof_aa = 5'd7; ha = 1; hb = 1; step();

    // branch wins over mc_start and load-use; FLUSH cycle suppresses forwards
    set_load_use(); branch_taken = 1; mc_start = 1; step();
    clr(); ha = 1; hb = 1; step();

    // multi-cycle op completing before timeout
    clr(); mc_start = 1; step();
    clr(); step(); step();
    mc_done = 1; step();
    // multi-cycle op timing out; branch ignored while waiting
    clr(); mc_start = 1; step();
    clr(); branch_taken = 1; step();
    clr(); for (int i = 0; i < 4; i++) step();

    // saturate the stall counter with load-use events
    for (int i = 0; i < 20; i++) begin
      set_load_use(); step();
    end
    check("stall_sat", stall_cnt, CNT_MAX);

    // asynchronous reset in the middle of a multi-cycle wait
    clr(); mc_start = 1; step();
    clr(); step();
    #2 reset_n = 0;
    #1;
    model_reset();
    check("arst_stall_cnt", stall_cnt, 0);
    check("arst_flush_cnt", flush_cnt, 0);
    check("arst_stall_pc", stall_pc, 0);
    check("arst_hold_ex", hold_ex, 0);
    @(negedge clk);
    reset_n = 1;
    step();
    check("arst_run_hold", hold_ex, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      ha           = 1'($urandom);
      hb           = 1'($urandom);
      ex_rw        = ($urandom_range(0, 3) != 0);
      ex_load      = 1'($urandom);
      ex_da        = 5'($urandom_range(0, 3));
      dof_aa       = 5'($urandom_range(0, 3));
      dof_ba       = 5'($urandom_range(0, 3));
      dof_ma       = ($urandom_range(0, 3) == 0);
      dof_mb       = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      mc_start     = ($urandom_range(0, 11) == 0);
      mc_done      = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
